aes_key_sched_visc: RTL

AES_KEY_SCHED_VISC -- requirements
Module: aes_key_sched_visc

---
 rtl/aes_visc_pkg.sv | 31 +++
 rtl/aes_sbox_visc.sv | 29 ++
 rtl/aes_key_sched_visc.sv | 127 ++++++++++++
 3 files changed

// File: rtl/aes_visc_pkg.sv
// Shared constants, round-constant table and FSM state type for the
// AES-128 round-key scheduler.
package aes_visc_pkg;

    localparam int NR = 10;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } ks_state_e;

    // Round constant applied when deriving round key idx+1 from round key idx.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox_visc.sv
// Combinational AES forward S-box; the table holds entry 0x00 in its top byte.
module aes_sbox_visc (
    input  logic [7:0] data,
    output logic [7:0] subst
);

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x sits at bit offset (255 - x) * 8, i.e. {~x, 3'b000}.
    assign subst = SBOX_TABLE[{~data, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_sched_visc.sv
// AES-128 round-key scheduler: accepts a cipher key and streams round keys
// 0..NR over a valid/ready handshake, one key per cycle when unstalled.
module aes_key_sched_visc #(
    parameter int NR = aes_visc_pkg::NR
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_key_valid,
    input  logic [127:0]   i_key,
    output logic           o_key_ready,
    output logic           o_rk_valid,
    output logic [127:0]   o_rk,
    output logic [3:0]     o_rk_idx,
    output logic           o_rk_last,
    input  logic           i_rk_ready
);

    import aes_visc_pkg::*;

    localparam logic [3:0] LAST_IDX = 4'(NR);

    ks_state_e      state_r;
    ks_state_e      state_nxt_s;
    logic [127:0]   rk_r;
    logic [127:0]   rk_nxt_s;
    logic [3:0]     idx_r;
    logic [3:0]     idx_nxt_s;
    logic           valid_r;
    logic           valid_nxt_s;

    logic           xfer_s;
    logic [31:0]    rot_word_s;
    logic [31:0]    sub_word_s;
    logic [31:0]    t_word_s;
    logic [31:0]    w4_s;
    logic [31:0]    w5_s;
    logic [31:0]    w6_s;
    logic [31:0]    w7_s;
    logic [127:0]   rk_expanded_s;

    assign xfer_s     = valid_r & i_rk_ready;
    assign rot_word_s = {rk_r[23:0], rk_r[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox_visc u_sbox (
            .data  (rot_word_s[8*g +: 8]),
            .subst (sub_word_s[8*g +: 8])
        );
    end

    // Next round key is derived purely from the registered current key.
    always_comb begin
        t_word_s      = sub_word_s ^ {rcon(idx_r), 24'h000000};
        w4_s          = rk_r[127:96] ^ t_word_s;
        w5_s          = rk_r[95:64]  ^ w4_s;
        w6_s          = rk_r[63:32]  ^ w5_s;
        w7_s          = rk_r[31:0]   ^ w6_s;
        rk_expanded_s = {w4_s, w5_s, w6_s, w7_s};
    end

    // Next-state and round-key register updates.
    always_comb begin
        state_nxt_s = state_r;
        rk_nxt_s    = rk_r;
        idx_nxt_s   = idx_r;
        valid_nxt_s = valid_r;
        case (state_r)
            ST_IDLE: begin
                if (i_key_valid) begin
                    rk_nxt_s    = i_key;
                    idx_nxt_s   = 4'd0;
                    valid_nxt_s = 1'b1;
                    state_nxt_s = ST_EXPAND;
                end else begin
                    valid_nxt_s = 1'b0;
                end
            end
            ST_EXPAND: begin
                if (xfer_s) begin
                    if (idx_r >= LAST_IDX) begin
                        // Final key consumed: keep key/index, drop valid.
                        valid_nxt_s = 1'b0;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        rk_nxt_s  = rk_expanded_s;
                        idx_nxt_s = idx_r + 4'd1;
                    end
                end else begin
                    state_nxt_s = ST_EXPAND;
                end
            end
            default: begin
                valid_nxt_s = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Round-key output register set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_r    <= 128'h0;
            idx_r   <= 4'd0;
            valid_r <= 1'b0;
        end else begin
            rk_r    <= rk_nxt_s;
            idx_r   <= idx_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    assign o_key_ready = (state_r == ST_IDLE);
    assign o_rk_valid  = valid_r;
    assign o_rk        = rk_r;
    assign o_rk_idx    = idx_r;
    assign o_rk_last   = valid_r & (idx_r == LAST_IDX);

endmodule
